app_add_err_monitor: RTL and testbench
======================================

APP_ADD_ERR_MONITOR -- requirements
Module: app_add_err_monitor

Interface
REQ-001 The block SHALL take parameter WINDOW, default 256, as the number of sample pairs per report, with a legal range of 1..65535.
REQ-002 The block SHALL take parameter SUM_W, default 48, as the width of the error-distance accumulator.
REQ-003 The block SHALL provide the following ports, clock and reset first:
- clk  in  1  single clock; all state is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that opens a measurement window.
- in_valid  in  1  a sample pair is present.
- in_ready  out  1  the block accepts a sample pair this cycle.
- ori_sum  in  32  exact adder result.
- app_sum  in  32  approximate adder result.
- rpt_valid  out  1  report fields are valid.
- rpt_ready  in  1  the consumer accepts the report.
- rpt_err_cnt  out  16  number of samples with ori_sum != app_sum.
- rpt_ed_sum  out  SUM_W  sum of error distances.
- rpt_ed_max  out  32  largest error distance.
- rpt_sat  out  1  rpt_ed_sum saturated.
- busy  out  1  the FSM is not in IDLE.

Function
REQ-004 The error distance ED SHALL be |ori_sum - app_sum|, computed unsigned over 32 bits with no wrap: the larger value minus the smaller.
REQ-005 The FSM SHALL have exactly three states, IDLE, ACCUM and REPORT, and SHALL be in IDLE after reset.
REQ-006 In IDLE, in_ready SHALL be 0 and samples SHALL be ignored.
REQ-007 A start pulse in IDLE SHALL clear all accumulators and the sample counter and move the FSM to ACCUM on the next cycle.
REQ-008 in_ready SHALL be 1 only in ACCUM; a sample is accepted on a cycle where in_valid and in_ready are both 1.
REQ-009 On each accepted sample:
- the sample counter SHALL increment;
- if ED != 0, err_cnt SHALL increment;
- ed_sum SHALL add ED, saturating at all-ones and setting the sticky sat flag;
- ed_max SHALL update to max(ed_max, ED).
REQ-010 When the sample counter reaches WINDOW, the FSM SHALL move to REPORT on the next cycle, and in_ready SHALL deassert in that same next cycle.
REQ-011 No sample SHALL be accepted after the WINDOW-th sample.
REQ-012 In REPORT, rpt_valid SHALL be 1 and all rpt_* fields SHALL hold stable until rpt_valid and rpt_ready are both 1.
REQ-013 On the report handshake the FSM SHALL return to IDLE; rpt_* fields SHALL keep their last values and rpt_valid SHALL drop to 0.
REQ-014 The latency from the last accepted sample to rpt_valid SHALL be exactly one cycle.
REQ-015 When rpt_ready is already 1 as rpt_valid rises, the report SHALL complete in that cycle.
REQ-016 A start pulse in ACCUM or REPORT SHALL be ignored; a start pulse in the cycle of the report handshake SHALL also be ignored, so a new window needs a start in IDLE.
REQ-017 With WINDOW=1, one accepted sample SHALL produce a report on the next cycle.
REQ-018 busy SHALL be 1 in ACCUM and REPORT and 0 in IDLE.

Reset
REQ-019 Asserting reset (low) SHALL immediately force:
- the FSM to IDLE;
- in_ready, rpt_valid and busy to 0;
- rpt_err_cnt, rpt_ed_sum, rpt_ed_max and rpt_sat to 0;
- all internal counters to 0.
REQ-020 Reset asserted mid-ACCUM or mid-REPORT SHALL discard the partial window with no report issued.
REQ-021 After reset deasserts, the block SHALL wait for a start pulse.

Configuration
REQ-022 With APP_ERR_MAX_EN defined, ed_max tracking SHALL be built as specified in REQ-009.
REQ-023 Without APP_ERR_MAX_EN, rpt_ed_max SHALL be tied to 0, no max register or comparator SHALL exist, and all other behaviour SHALL be unchanged.

Structure
REQ-024 The shared defines package SHALL hold:
- typedef err_stats_t, a struct of err_cnt, ed_sum, ed_max and sat;
- the FSM state enum app_err_state_t;
- the constant APP_ERR_CNT_W = 16.
REQ-025 The 32-bit absolute-difference datapath SHALL be one combinational sub-module named abs_diff32, with inputs a and b and output d.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- WINDOW=4, start, then pairs (5,5), (10,12), (0,0xFFFFFFFF), (7,3) with rpt_ready held 1 → err_cnt=3, ed_sum=0x100000005, ed_max=0xFFFFFFFF, sat=0.
- SUM_W=33, WINDOW=4, four pairs (0,0xFFFFFFFF) → ed_sum=0x1FFFFFFFF, sat=1.
- rpt_ready held 0 for 10 cycles after rpt_valid → rpt_valid and all fields stable for those 10 cycles; in_ready stays 0 while in_valid is held 1.
- reset asserted low after 2 of 4 samples → all outputs 0 and state IDLE immediately; a later start gives a fresh window whose report counts only new samples.
- start pulsed during ACCUM and during REPORT → no effect on counters or state.
- build without APP_ERR_MAX_EN → rpt_ed_max=0 for the scenario-1 stimulus, all other fields identical to scenario 1.

Source files
------------

// File: rtl/app_add_err_monitor_pkg.sv
// Shared definitions for the approximate-adder error monitor: FSM state
// encoding, report statistics bundle and counter width.
package app_add_err_monitor_pkg;

    localparam int APP_ERR_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } app_err_state_t;

    // ed_sum is sized for the widest supported accumulator (SUM_W <= 64).
    typedef struct packed {
        logic [APP_ERR_CNT_W-1:0] err_cnt;
        logic [63:0]              ed_sum;
        logic [31:0]              ed_max;
        logic                     sat;
    } err_stats_t;

endpackage

// File: rtl/app_add_err_monitor_abs_diff.sv
// Unsigned 32-bit absolute difference: larger operand minus smaller, never wraps.
module abs_diff32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] d
);

    assign d = (a >= b) ? (a - b) : (b - a);

endmodule

// File: rtl/app_add_err_monitor.sv
// Error-distance monitor for an approximate adder: accumulates WINDOW sample
// pairs, then presents a held report. Define APP_ERR_MAX_EN to build ed_max tracking.
module app_add_err_monitor
    import app_add_err_monitor_pkg::*;
#(
    parameter int WINDOW = 256,
    parameter int SUM_W  = 48
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              ori_sum,
    input  logic [31:0]              app_sum,
    output logic                     rpt_valid,
    input  logic                     rpt_ready,
    output logic [APP_ERR_CNT_W-1:0] rpt_err_cnt,
    output logic [SUM_W-1:0]         rpt_ed_sum,
    output logic [31:0]              rpt_ed_max,
    output logic                     rpt_sat,
    output logic                     busy,
    output logic [1:0]               dbg_state
);

    // Handshakes: a sample moves when in_valid && in_ready; a report moves when
    // rpt_valid && rpt_ready. Producers hold data stable while waiting.
    localparam logic [15:0] WINDOW_M1 = 16'(WINDOW - 1);

    app_err_state_t          r_state;
    app_err_state_t          w_next_state;
    logic                    w_clear;
    logic                    w_accept;
    logic [31:0]             w_ed;
    logic [15:0]             r_cnt;
    logic [APP_ERR_CNT_W-1:0] r_err_cnt;
    logic [SUM_W-1:0]        r_ed_sum;
    logic                    r_sat;
    logic [SUM_W:0]          w_sum_ext;

    abs_diff32 u_abs_diff (
        .a (ori_sum),
        .b (app_sum),
        .d (w_ed)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_clear      = 1'b0;
        in_ready     = 1'b0;
        rpt_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_clear      = 1'b1;
                    w_next_state = ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && (r_cnt == WINDOW_M1)) begin
                    w_next_state = REPORT;
                end
            end
            REPORT: begin
                rpt_valid = 1'b1;
                if (rpt_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign w_accept  = in_valid & in_ready;
    // One spare bit catches accumulator overflow; requires SUM_W >= 32.
    assign w_sum_ext = {1'b0, r_ed_sum} + {{(SUM_W + 1 - 32){1'b0}}, w_ed};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_err_cnt <= '0;
            r_ed_sum  <= '0;
            r_sat     <= 1'b0;
        end else if (w_clear) begin
            r_cnt     <= '0;
            r_err_cnt <= '0;
            r_ed_sum  <= '0;
            r_sat     <= 1'b0;
        end else if (w_accept) begin
            r_cnt     <= r_cnt + 16'd1;
            r_err_cnt <= r_err_cnt + APP_ERR_CNT_W'(w_ed != 32'd0);
            r_ed_sum  <= w_sum_ext[SUM_W] ? {SUM_W{1'b1}} : w_sum_ext[SUM_W-1:0];
            r_sat     <= r_sat | w_sum_ext[SUM_W];
        end
    end

`ifdef APP_ERR_MAX_EN
    logic [31:0] r_ed_max;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ed_max <= '0;
        end else if (w_clear) begin
            r_ed_max <= '0;
        end else if (w_accept && (w_ed > r_ed_max)) begin
            r_ed_max <= w_ed;
        end
    end

    assign rpt_ed_max = r_ed_max;
`else
    assign rpt_ed_max = 32'd0;
`endif

    assign rpt_err_cnt = r_err_cnt;
    assign rpt_ed_sum  = r_ed_sum;
    assign rpt_sat     = r_sat;
    assign busy        = (r_state != IDLE);
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_app_add_err_monitor.sv
// Bench for app_add_err_monitor: directed scenarios plus randomized windows
// checked against a queue-based statistics model.
module tb_app_add_err_monitor;
    import app_add_err_monitor_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_ab;
    logic        start_c;
    logic        in_valid;
    logic        rpt_ready;
    logic [31:0] ori_sum;
    logic [31:0] app_sum;

    logic        a_in_ready, a_rpt_valid, a_sat, a_busy;
    logic [15:0] a_err_cnt;
    logic [47:0] a_ed_sum;
    logic [31:0] a_ed_max;
    logic [1:0]  a_state;

    logic        b_in_ready, b_rpt_valid, b_sat, b_busy;
    logic [15:0] b_err_cnt;
    logic [32:0] b_ed_sum;
    logic [31:0] b_ed_max;
    logic [1:0]  b_state;

    logic        c_in_ready, c_rpt_valid, c_sat, c_busy;
    logic [15:0] c_err_cnt;
    logic [47:0] c_ed_sum;
    logic [31:0] c_ed_max;
    logic [1:0]  c_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] d_ori[4];
    logic [31:0] d_app[4];
    logic [31:0] q_ori[$];
    logic [31:0] q_app[$];

    always #5 clk = ~clk;

    app_add_err_monitor #(.WINDOW(4), .SUM_W(48)) u_dut_a (
        .clk(clk), .reset(reset), .start(start_ab), .in_valid(in_valid),
        .in_ready(a_in_ready), .ori_sum(ori_sum), .app_sum(app_sum),
        .rpt_valid(a_rpt_valid), .rpt_ready(rpt_ready), .rpt_err_cnt(a_err_cnt),
        .rpt_ed_sum(a_ed_sum), .rpt_ed_max(a_ed_max), .rpt_sat(a_sat),
        .busy(a_busy), .dbg_state(a_state)
    );

    app_add_err_monitor #(.WINDOW(4), .SUM_W(33)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_ab), .in_valid(in_valid),
        .in_ready(b_in_ready), .ori_sum(ori_sum), .app_sum(app_sum),
        .rpt_valid(b_rpt_valid), .rpt_ready(rpt_ready), .rpt_err_cnt(b_err_cnt),
        .rpt_ed_sum(b_ed_sum), .rpt_ed_max(b_ed_max), .rpt_sat(b_sat),
        .busy(b_busy), .dbg_state(b_state)
    );

    app_add_err_monitor #(.WINDOW(1), .SUM_W(48)) u_dut_c (
        .clk(clk), .reset(reset), .start(start_c), .in_valid(in_valid),
        .in_ready(c_in_ready), .ori_sum(ori_sum), .app_sum(app_sum),
        .rpt_valid(c_rpt_valid), .rpt_ready(rpt_ready), .rpt_err_cnt(c_err_cnt),
        .rpt_ed_sum(c_ed_sum), .rpt_ed_max(c_ed_max), .rpt_sat(c_sat),
        .busy(c_busy), .dbg_state(c_state)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Statistics of every pair accepted in the current window, from the rules.
    function automatic err_stats_t model(input int sum_w);
        err_stats_t      s;
        longint unsigned raw;
        longint unsigned limit;
        longint unsigned ed;
        s     = '0;
        raw   = 0;
        limit = (64'd1 << sum_w) - 64'd1;
        foreach (q_ori[i]) begin
            ed = (q_ori[i] > q_app[i]) ? 64'(q_ori[i] - q_app[i]) : 64'(q_app[i] - q_ori[i]);
            if (ed != 0) s.err_cnt = s.err_cnt + 16'd1;
            raw = raw + ed;
            if (ed > 64'(s.ed_max)) s.ed_max = ed[31:0];
        end
        if (raw > limit) begin
            s.ed_sum = limit;
            s.sat    = 1'b1;
        end else begin
            s.ed_sum = raw;
        end
`ifndef APP_ERR_MAX_EN
        s.ed_max = '0;
`endif
        return s;
    endfunction

    task automatic check_fields(input string pfx);
        err_stats_t ea;
        err_stats_t eb;
        ea = model(48);
        eb = model(33);
        chk({pfx, ".a_err_cnt"}, 64'(a_err_cnt), 64'(ea.err_cnt));
        chk({pfx, ".a_ed_sum"},  64'(a_ed_sum),  ea.ed_sum);
        chk({pfx, ".a_ed_max"},  64'(a_ed_max),  64'(ea.ed_max));
        chk({pfx, ".a_sat"},     64'(a_sat),     64'(ea.sat));
        chk({pfx, ".b_err_cnt"}, 64'(b_err_cnt), 64'(eb.err_cnt));
        chk({pfx, ".b_ed_sum"},  64'(b_ed_sum),  eb.ed_sum);
        chk({pfx, ".b_ed_max"},  64'(b_ed_max),  64'(eb.ed_max));
        chk({pfx, ".b_sat"},     64'(b_sat),     64'(eb.sat));
    endtask

    task automatic check_zero(input string pfx);
        chk({pfx, ".a_state"},  64'(a_state), 64'(IDLE));
        chk({pfx, ".a_ready"},  64'(a_in_ready), 64'd0);
        chk({pfx, ".a_rvalid"}, 64'(a_rpt_valid), 64'd0);
        chk({pfx, ".a_busy"},   64'(a_busy), 64'd0);
        chk({pfx, ".a_fields"}, {a_err_cnt, a_ed_max, 15'd0, a_sat}, 64'd0);
        chk({pfx, ".a_sum"},    64'(a_ed_sum), 64'd0);
        chk({pfx, ".b_busy"},   64'(b_busy), 64'd0);
        chk({pfx, ".b_fields"}, {b_err_cnt, b_ed_max, 15'd0, b_sat}, 64'd0);
        chk({pfx, ".b_sum"},    64'(b_ed_sum), 64'd0);
        chk({pfx, ".c_busy"},   64'(c_busy), 64'd0);
    endtask

    // One full window on the WINDOW=4 instances using d_ori/d_app.
    task automatic run_window(input string pfx, input int stall, input bit hold_ready,
                              input bit poke_start, input bit gaps);
        int acc;
        int tries;
        bit v;
        q_ori.delete();
        q_app.delete();
        rpt_ready = hold_ready;
        start_ab  = 1'b1;
        step();
        start_ab  = 1'b0;
        chk({pfx, ".accum_busy"}, 64'(a_busy), 64'd1);
        acc   = 0;
        tries = 0;
        while (acc < 4) begin
            chk({pfx, ".in_ready"}, 64'({a_in_ready, b_in_ready}), 64'd3);
            chk({pfx, ".no_rpt"}, 64'(a_rpt_valid), 64'd0);
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (tries > 20) v = 1'b1;
            in_valid = v;
            ori_sum  = v ? d_ori[acc] : $urandom;
            app_sum  = v ? d_app[acc] : $urandom;
            start_ab = poke_start && (acc == 2);
            step();
            if (v) begin
                q_ori.push_back(d_ori[acc]);
                q_app.push_back(d_app[acc]);
                acc++;
            end
            tries++;
        end
        in_valid = 1'b1;
        ori_sum  = 32'd1;
        app_sum  = 32'd9;
        for (int k = 0; k <= stall; k++) begin
            chk({pfx, ".rpt_valid"}, 64'({a_rpt_valid, b_rpt_valid}), 64'd3);
            chk({pfx, ".rpt_ready_blk"}, 64'({a_in_ready, b_in_ready}), 64'd0);
            chk({pfx, ".rpt_busy"}, 64'(a_busy), 64'd1);
            check_fields({pfx, ".rpt"});
            rpt_ready = hold_ready || (k == stall);
            start_ab  = poke_start;
            step();
        end
        start_ab  = 1'b0;
        in_valid  = 1'b0;
        rpt_ready = 1'b0;
        chk({pfx, ".done_valid"}, 64'({a_rpt_valid, b_rpt_valid}), 64'd0);
        chk({pfx, ".done_state"}, 64'(a_state), 64'(IDLE));
        check_fields({pfx, ".kept"});
        step();
        chk({pfx, ".still_idle"}, 64'({a_busy, b_busy}), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        start_ab  = 1'b0;
        start_c   = 1'b0;
        in_valid  = 1'b0;
        rpt_ready = 1'b0;
        ori_sum   = '0;
        app_sum   = '0;
        step();
        step();
        check_zero("reset");
        reset = 1'b1;
        in_valid = 1'b1;
        step();
        step();
        chk("idle_ignores", 64'({a_in_ready, a_busy, a_err_cnt}), 64'd0);
        in_valid = 1'b0;

        d_ori = '{32'd5, 32'd10, 32'd0, 32'd7};
        d_app = '{32'd5, 32'd12, 32'hFFFF_FFFF, 32'd3};
        run_window("s1", 0, 1'b1, 1'b0, 1'b0);
        chk("s1.err_const", 64'(a_err_cnt), 64'd3);
        chk("s1.sum_const", 64'(a_ed_sum), 64'h1_0000_0005);
`ifdef APP_ERR_MAX_EN
        chk("s1.max_const", 64'(a_ed_max), 64'hFFFF_FFFF);
`else
        chk("s1.max_const", 64'(a_ed_max), 64'd0);
`endif

        d_ori = '{32'd0, 32'd0, 32'd0, 32'd0};
        d_app = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        run_window("s2", 2, 1'b0, 1'b0, 1'b0);
        chk("s2.b_sum_const", 64'(b_ed_sum), 64'h1_FFFF_FFFF);
        chk("s2.b_sat_const", 64'(b_sat), 64'd1);

        d_ori = '{32'd100, 32'd200, 32'd300, 32'd400};
        d_app = '{32'd90, 32'd200, 32'd333, 32'd1};
        run_window("s3_stall", 10, 1'b0, 1'b0, 1'b1);

        run_window("s5_poke", 3, 1'b0, 1'b1, 1'b0);

        // Reset mid-window discards the partial window immediately.
        rpt_ready = 1'b0;
        start_ab  = 1'b1;
        step();
        start_ab  = 1'b0;
        in_valid  = 1'b1;
        ori_sum   = 32'd50;
        app_sum   = 32'd20;
        step();
        step();
        in_valid  = 1'b0;
        chk("s4.mid_busy", 64'(a_busy), 64'd1);
        reset = 1'b0;
        #1;
        check_zero("s4.async");
        step();
        reset = 1'b1;
        step();
        check_zero("s4.after");
        d_ori = '{32'd8, 32'd8, 32'd1, 32'hFFFF_0000};
        d_app = '{32'd9, 32'd8, 32'd1, 32'h0000_FFFF};
        run_window("s4_fresh", 1, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 4; i++) begin
                d_ori[i] = $urandom;
                case ($urandom_range(0, 2))
                    0: d_app[i] = d_ori[i];
                    1: d_app[i] = d_ori[i] + 32'($urandom_range(0, 15)) - 32'd8;
                    default: d_app[i] = $urandom;
                endcase
            end
            if ($urandom_range(0, 1) == 1) run_window($sformatf("rnd%0d", n), 0, 1'b1, 1'b0, 1'b1);
            else run_window($sformatf("rnd%0d", n), $urandom_range(0, 4), 1'b0, 1'b0, 1'b1);
        end

        // WINDOW=1 instance: one sample gives a report on the next cycle.
        start_c = 1'b1;
        step();
        start_c = 1'b0;
        chk("w1.ready", 64'(c_in_ready), 64'd1);
        in_valid  = 1'b1;
        ori_sum   = 32'd100;
        app_sum   = 32'd40;
        rpt_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        chk("w1.rpt_valid", 64'(c_rpt_valid), 64'd1);
        chk("w1.in_ready", 64'(c_in_ready), 64'd0);
        chk("w1.err_cnt", 64'(c_err_cnt), 64'd1);
        chk("w1.ed_sum", 64'(c_ed_sum), 64'd60);
`ifdef APP_ERR_MAX_EN
        chk("w1.ed_max", 64'(c_ed_max), 64'd60);
`else
        chk("w1.ed_max", 64'(c_ed_max), 64'd0);
`endif
        chk("w1.sat", 64'(c_sat), 64'd0);
        chk("w1.a_idle", 64'(a_busy), 64'd0);
        step();
        rpt_ready = 1'b0;
        chk("w1.done", 64'({c_rpt_valid, c_busy}), 64'd0);
        chk("w1.kept", 64'(c_ed_sum), 64'd60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
